// File: rtl/park_pkg.sv
// Shared types, default widths and saturation for the Park stages.
// Exports: state_e, D_WIDTH, Q_BITS, ACC_W, saturate().
package park_pkg;

  localparam int D_WIDTH = 32;
  localparam int Q_BITS  = 10;
  localparam int ACC_W   = 2*D_WIDTH+1;

  typedef enum logic [2:0] {
    IDLE,
    M0,
    M1,
    M2,
    M3
  } state_e;

  // Clamp x into the signed w-bit range.
  // Result is sign-extended; callers keep the low w bits.
  function automatic logic signed [ACC_W-1:0] saturate(
    input logic signed [ACC_W-1:0] x,
    input int                      w
  );
    logic signed [ACC_W-1:0] hi;
    logic signed [ACC_W-1:0] lo;
    hi = (ACC_W'(1) <<< (w-1)) - ACC_W'(1);
    lo = ~hi;
    if (x > hi)      return hi;
    else if (x < lo) return lo;
    else             return x;
  endfunction

endpackage

// File: rtl/park_transform_mac.sv
// Shared signed multiplier with add/subtract accumulate.
// Ports: i_a, i_b operands; i_acc running sum; i_sub subtract; o_acc next sum.
module park_mac #(
  parameter int D_WIDTH = 32,
  parameter int ACC_W   = 2*D_WIDTH+1
) (
  input  logic signed [D_WIDTH-1:0] i_a,
  input  logic signed [D_WIDTH-1:0] i_b,
  input  logic signed [ACC_W-1:0]   i_acc,
  input  logic                      i_sub,
  output logic signed [ACC_W-1:0]   o_acc
);

  logic signed [2*D_WIDTH-1:0] w_prod;
  logic signed [ACC_W-1:0]     w_ext;

  assign w_prod = i_a * i_b;
  assign w_ext  = ACC_W'(w_prod);
  assign o_acc  = i_sub ? i_acc - w_ext
                        : i_acc + w_ext;

endmodule

// File: rtl/park_transform.sv
// Forward Park transform, four MACs on one multiplier per request.
// Ports: clk, reset(n), alpha/beta/sin/cos, start in; D/Q, busy, done out.
module park_transform
  import park_pkg::*;
#(
  parameter int D_WIDTH = park_pkg::D_WIDTH,
  parameter int Q_BITS  = park_pkg::Q_BITS
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic signed [D_WIDTH-1:0] alpha,
  input  logic signed [D_WIDTH-1:0] beta,
  input  logic signed [D_WIDTH-1:0] sin,
  input  logic signed [D_WIDTH-1:0] cos,
  input  logic                      start,
  output logic signed [D_WIDTH-1:0] D,
  output logic signed [D_WIDTH-1:0] Q,
  output logic                      busy,
  output logic                      done
);

  localparam int AW = 2*D_WIDTH+1;

  state_e                    r_state;
  logic signed [D_WIDTH-1:0] r_alpha;
  logic signed [D_WIDTH-1:0] r_beta;
  logic signed [D_WIDTH-1:0] r_sin;
  logic signed [D_WIDTH-1:0] r_cos;
  logic signed [AW-1:0]      r_acc_d;
  logic signed [AW-1:0]      r_acc_q;
  logic signed [D_WIDTH-1:0] r_d;
  logic signed [D_WIDTH-1:0] r_q;
  logic                      r_busy;
  logic                      r_done;

  logic signed [D_WIDTH-1:0] w_a;
  logic signed [D_WIDTH-1:0] w_b;
  logic signed [AW-1:0]      w_acc;
  logic                      w_sub;
  logic signed [AW-1:0]      w_mac;
  logic signed [AW-1:0]      w_d_shr;
  logic signed [AW-1:0]      w_q_shr;
  logic signed [D_WIDTH-1:0] w_d;
  logic signed [D_WIDTH-1:0] w_q;

  always_comb begin
    w_a   = r_alpha;
    w_b   = r_cos;
    w_acc = r_acc_d;
    w_sub = 1'b0;
    unique case (r_state)
      M1: begin
        w_a = r_beta;
        w_b = r_sin;
      end
      M2: begin
        w_a   = r_beta;
        w_b   = r_cos;
        w_acc = r_acc_q;
      end
      M3: begin
        w_a   = r_alpha;
        w_b   = r_sin;
        w_acc = r_acc_q;
        w_sub = 1'b1;
      end
      default: ;
    endcase
  end

  park_mac #(
    .D_WIDTH (D_WIDTH),
    .ACC_W   (AW)
  ) u_mac (
    .i_a   (w_a),
    .i_b   (w_b),
    .i_acc (w_acc),
    .i_sub (w_sub),
    .o_acc (w_mac)
  );

  // In M3 the D sum is already final; Q's final sum is the MAC output.
  assign w_d_shr = r_acc_d >>> Q_BITS;
  assign w_q_shr = w_mac >>> Q_BITS;
  assign w_d = D_WIDTH'(saturate(ACC_W'(w_d_shr), D_WIDTH));
  assign w_q = D_WIDTH'(saturate(ACC_W'(w_q_shr), D_WIDTH));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_alpha <= '0;
      r_beta  <= '0;
      r_sin   <= '0;
      r_cos   <= '0;
      r_acc_d <= '0;
      r_acc_q <= '0;
      r_d     <= '0;
      r_q     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_alpha <= alpha;
            r_beta  <= beta;
            r_sin   <= sin;
            r_cos   <= cos;
            r_acc_d <= '0;
            r_acc_q <= '0;
            r_busy  <= 1'b1;
            r_state <= M0;
          end
        end
        M0: begin
          r_acc_d <= w_mac;
          r_state <= M1;
        end
        M1: begin
          r_acc_d <= w_mac;
          r_state <= M2;
        end
        M2: begin
          r_acc_q <= w_mac;
          r_state <= M3;
        end
        M3: begin
          r_acc_q <= w_mac;
          r_d     <= w_d;
          r_q     <= w_q;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign D    = r_d;
  assign Q    = r_q;
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: doc/park_transform.md
# park_transform

Sequential forward Park transform: converts stationary-frame currents (alpha, beta) and a rotor-angle sine/cosine pair into rotating-frame D/Q values in Q_BITS fixed point. It sits in the FOC current-feedback path, after the Clarke stage and before the D/Q PI controllers. It mirrors the inverse Park stage on the drive side. One time-shared signed multiplier performs four multiply-accumulates per transform under a start/busy/done handshake.

## Interface
- D_WIDTH, 32: width of all data ports, two's complement.
- Q_BITS, 10: fractional bits of sin/cos (1.0 = 2^Q_BITS).
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- alpha  in  D_WIDTH  signed stationary-frame alpha; sampled on accepted start.
- beta  in  D_WIDTH  signed stationary-frame beta; sampled on accepted start.
- sin  in  D_WIDTH  signed sin(theta), Q_BITS fractional; sampled on accepted start.
- cos  in  D_WIDTH  signed cos(theta), Q_BITS fractional; sampled on accepted start.
- start  in  1  request a transform; honoured only in IDLE.
- D  out  D_WIDTH  signed direct-axis result; held until the next completion.
- Q  out  D_WIDTH  signed quadrature-axis result; held until the next completion.
- busy  out  1  high in states M0..M3.
- done  out  1  one-cycle pulse when D/Q update.

## Operation
- D = (alpha·cos + beta·sin) >>> Q_BITS; Q = (beta·cos − alpha·sin) >>> Q_BITS.
- FSM: IDLE → M0 → M1 → M2 → M3 → IDLE.
- IDLE: start=1 captures alpha/beta/sin/cos into operand registers, clears both accumulators, goes to M0. start=0 stays in IDLE.
- M0: acc_d += alpha·cos.
- M1: acc_d += beta·sin.
- M2: acc_q += beta·cos.
- M3: acc_q −= alpha·sin. The final sums are shifted, saturated, and loaded into D/Q. done is set and the FSM returns to IDLE.
- Products are full 2·D_WIDTH signed. Accumulators are 2·D_WIDTH+1 bits, so there is no internal overflow.
- Scaling is an arithmetic right shift by Q_BITS (truncate toward −∞, no rounding).
- Saturation to [−2^(D_WIDTH−1), 2^(D_WIDTH−1)−1] after the shift. There is no wrap-around.
- Operand registers isolate the computation. Input changes after acceptance do not affect the result.

## Timing
- Reset state: FSM IDLE; D, Q, accumulators and operand registers all 0; busy=0; done=0.
- Accept edge E0: IDLE with start=1. busy=1 from after E0 through E4.
- Edges E1..E4 execute M0..M3. D, Q and done=1 are visible after E4, so latency is 4 cycles from the accept edge.
- done is high exactly one cycle. busy=0 in that same cycle.
- start during busy is ignored. It is not queued.
- start held high continuously gives a new accept at E5, E10, … (throughput 1 per 5 cycles).
- start asserted in the done cycle is accepted.
- Reset asserted mid-transform forces the reset state immediately. No done is produced for the aborted transform.

## Structure
- Shared package park_pkg:
  - state enum (IDLE, M0, M1, M2, M3);
  - default D_WIDTH/Q_BITS constants;
  - saturate function (2·D_WIDTH+1 → D_WIDTH), reused by the inverse stage.
- Sub-module park_mac: one signed D_WIDTH×D_WIDTH multiplier with an add/subtract accumulate input. The top module muxes operands and selects the accumulator by state.

## Test plan
All scenarios use Q_BITS=10.
- θ=0 (cos=1024, sin=0), alpha=500, beta=−300, start → D=500, Q=−300, done 4 cycles after accept, busy high for 4 cycles.
- θ=90° (cos=0, sin=1024), alpha=500, beta=−300 → D=−300, Q=−500.
- θ=45° (cos=sin=724), alpha=1024, beta=0 → D=724, Q=−724. With alpha=−1, beta=0 → D=−1 (floor), Q=0.
- Saturation: alpha=beta=2^31−1, cos=sin=1024 → D=2147483647, Q=0. With alpha=beta=−2^31 → D=−2147483648.
- Handshake:
  - start re-pulsed in M1 is ignored (exactly one done);
  - inputs changed after accept do not alter the result;
  - start held high gives done every 5 cycles.
- Reset low during M2 → D=Q=0, busy=0, no done. A new start after release gives a correct result.
